// File: rtl/psum_unpack.sv
// psum_unpack: splits 64-bit packed partial-sum words into a stream of
// DW-bit lanes, lane 0 (MSBs) first, with word-last and plane-last flags.
module psum_unpack #(
  parameter int unsigned DW          = 16,
  parameter int unsigned LANES       = 4,
  parameter int unsigned PLANE_WORDS = 8,
  localparam int unsigned WW = DW * LANES,
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int unsigned CW = (PLANE_WORDS > 1) ? $clog2(PLANE_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_plane_last,
  output logic [CW-1:0] word_cnt
);

  logic [WW-1:0] data_q;
  logic [LW-1:0] lane_q;
  logic          full_q;
  logic [CW-1:0] wcnt_q;

  logic lane_is_last;
  logic out_fire;
  logic last_fire;
  logic in_fire;

  // Handshake decode; in_ready looks through out_ready so words stream back-to-back.
  always_comb begin
    lane_is_last   = (lane_q == LW'(LANES - 1));
    out_fire       = full_q & out_ready;
    last_fire      = out_fire & lane_is_last;
    in_ready       = ~full_q | last_fire;
    in_fire        = in_valid & in_ready;
    out_valid      = full_q;
    out_last       = full_q & lane_is_last;
    out_plane_last = out_last & (wcnt_q == CW'(PLANE_WORDS - 1));
    word_cnt       = wcnt_q;
  end

  // Lane select from the held word; lane 0 sits in the top DW bits.
  always_comb begin
    out_data = data_q[WW-1 -: DW];
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LW'(i)) begin
        out_data = data_q[DW*(LANES-i)-1 -: DW];
      end
    end
  end

  // Word buffer, lane pointer and full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      lane_q <= '0;
      full_q <= 1'b0;
    end else if (in_fire) begin
      data_q <= in_data;
      lane_q <= '0;
      full_q <= 1'b1;
    end else if (out_fire) begin
      if (lane_is_last) begin
        full_q <= 1'b0;
        lane_q <= '0;
      end else begin
        lane_q <= lane_q + LW'(1);
      end
    end
  end

  // Word-within-plane counter, advanced as each word's final lane leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
    end else if (last_fire) begin
      if (wcnt_q == CW'(PLANE_WORDS - 1)) begin
        wcnt_q <= '0;
      end else begin
        wcnt_q <= wcnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_psum_unpack.sv
// Bench for psum_unpack: table of packed words with hand-written lane values,
// a lane scoreboard, and two DUTs (8-word and 2-word planes) on shared stimulus.
module tb_psum_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_last_a, opl_a;
  logic [15:0] out_data_a;
  logic [2:0]  word_cnt_a;
  logic        in_ready_b, out_valid_b, out_last_b, opl_b;
  logic [15:0] out_data_b;
  logic [0:0]  word_cnt_b;

  always #5 clk = ~clk;

  psum_unpack #(.DW(16), .LANES(4), .PLANE_WORDS(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_last(out_last_a), .out_plane_last(opl_a),
    .word_cnt(word_cnt_a)
  );

  psum_unpack #(.DW(16), .LANES(4), .PLANE_WORDS(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_last(out_last_b), .out_plane_last(opl_b),
    .word_cnt(word_cnt_b)
  );

  typedef struct {
    logic [63:0] word;
    logic [15:0] lane [4];
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        pl8;
    logic        pl2;
    logic [2:0]  wc8;
    logic [0:0]  wc2;
  } exp_t;

  vec_t tbl [8];
  exp_t q [$];
  logic [15:0] cur_lane [4];
  int checks = 0;
  int failures = 0;
  int m_w8 = 0;
  int m_w2 = 0;
  logic m_in_fire = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [63:0] w,
                         input logic [15:0] l0, input logic [15:0] l1,
                         input logic [15:0] l2, input logic [15:0] l3);
    tbl[i].word    = w;
    tbl[i].lane[0] = l0;
    tbl[i].lane[1] = l1;
    tbl[i].lane[2] = l2;
    tbl[i].lane[3] = l3;
  endtask

  // Scoreboard/monitor: inputs are stable at the falling edge, so predict the
  // coming rising edge here and compare outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_w8 = 0;
      m_w2 = 0;
      m_in_fire = 1'b0;
    end else begin
      logic exp_valid, exp_ir;
      exp_valid = (q.size() != 0);
      exp_ir    = (q.size() == 0) || (out_ready && q.size() == 1);
      chk("out_valid_a", 64'(out_valid_a), 64'(exp_valid));
      chk("out_valid_b", 64'(out_valid_b), 64'(exp_valid));
      chk("in_ready_a", 64'(in_ready_a), 64'(exp_ir));
      chk("in_ready_b", 64'(in_ready_b), 64'(exp_ir));
      if (exp_valid) begin
        chk("out_data_a", 64'(out_data_a), 64'(q[0].data));
        chk("out_data_b", 64'(out_data_b), 64'(q[0].data));
        chk("out_last_a", 64'(out_last_a), 64'(q[0].last));
        chk("out_last_b", 64'(out_last_b), 64'(q[0].last));
        chk("plane_last_8", 64'(opl_a), 64'(q[0].pl8));
        chk("plane_last_2", 64'(opl_b), 64'(q[0].pl2));
        chk("word_cnt_8", 64'(word_cnt_a), 64'(q[0].wc8));
        chk("word_cnt_2", 64'(word_cnt_b), 64'(q[0].wc2));
      end else begin
        chk("out_last_idle", 64'(out_last_a), 64'(0));
        chk("plane_last_idle", 64'(opl_a), 64'(0));
      end
      if (exp_valid && out_ready) void'(q.pop_front());
      m_in_fire = in_valid && exp_ir;
      if (m_in_fire) begin
        for (int j = 0; j < 4; j++) begin
          exp_t e;
          e.data = cur_lane[j];
          e.last = (j == 3);
          e.pl8  = (j == 3) && (m_w8 == 7);
          e.pl2  = (j == 3) && (m_w2 == 1);
          e.wc8  = 3'(m_w8);
          e.wc2  = 1'(m_w2);
          q.push_back(e);
        end
        m_w8 = (m_w8 + 1) % 8;
        m_w2 = (m_w2 + 1) % 2;
      end
    end
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic send(input int idx);
    logic f;
    in_data  = tbl[idx].word;
    for (int j = 0; j < 4; j++) cur_lane[j] = tbl[idx].lane[j];
    in_valid = 1'b1;
    f = 1'b0;
    for (int n = 0; n < 50 && !f; n++) begin
      @(negedge clk); #1;
      f = m_in_fire;
      @(posedge clk); #1;
    end
    if (!f) chk("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_qsize(input int s, input string name);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk); #1;
      done = (q.size() == s);
      @(posedge clk); #1;
    end
    if (!done) chk(name, 64'(0), 64'(1));
  endtask

  task automatic drain();
    wait_qsize(0, "drain_timeout");
    chk("drained_out_valid", 64'(out_valid_a), 64'(0));
    chk("drained_in_ready", 64'(in_ready_a), 64'(1));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    set_vec(0, 64'h1111_2222_3333_4444, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    set_vec(1, 64'hAAAA_BBBB_CCCC_DDDD, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    set_vec(2, 64'h0001_0002_0003_0004, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    set_vec(3, 64'hDEAD_BEEF_0123_4567, 16'hDEAD, 16'hBEEF, 16'h0123, 16'h4567);
    set_vec(4, 64'hFFFF_0000_8000_7FFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF);
    set_vec(5, 64'h1234_5678_9ABC_DEF0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    set_vec(6, 64'h0F0F_F0F0_5A5A_A5A5, 16'h0F0F, 16'hF0F0, 16'h5A5A, 16'hA5A5);
    set_vec(7, 64'hCAFE_F00D_B00B_1E55, 16'hCAFE, 16'hF00D, 16'hB00B, 16'h1E55);
    for (int j = 0; j < 4; j++) cur_lane[j] = 16'h0;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid_a), 64'(0));
    chk("rst_out_data", 64'(out_data_a), 64'(0));
    chk("rst_out_last", 64'(out_last_a), 64'(0));
    chk("rst_plane_last", 64'(opl_a), 64'(0));
    chk("rst_word_cnt", 64'(word_cnt_a), 64'(0));
    chk("rst_in_ready", 64'(in_ready_a), 64'(1));

    // Single word, then back-to-back pair.
    send(0);
    drain();
    send(1);
    send(2);
    drain();

    // Backpressure for three cycles while lane 1 is presented.
    send(3);
    wait_qsize(3, "bp_timeout");
    out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    drain();

    // Plane boundary on the 2-word DUT, with fresh counters.
    pulse_reset();
    send(4);
    send(5);
    send(6);
    drain();

    // Remaining table entries through the scoreboard.
    for (int i = 0; i < 8; i++) send(i);
    drain();

    // Asynchronous reset while lane 2 is presented.
    send(7);
    wait_qsize(2, "mid_timeout");
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid_a), 64'(0));
    chk("mid_rst_out_data", 64'(out_data_a), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready_a), 64'(1));
    chk("mid_rst_word_cnt", 64'(word_cnt_a), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    send(0);
    drain();

    // Input stall of five cycles between words.
    repeat (5) begin @(posedge clk); #1; end
    send(5);
    drain();

    chk("queue_empty_end", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
